// File: rtl/pio_in_edge_irq.sv
// Avalon-MM input PIO: synchroniser, edge capture, per-bit IRQ mask and level IRQ.
// Optional per-bit debounce filter compiled in with `define PIO_IN_DEBOUNCE_EN.
module pio_in_edge_irq #(
    parameter int WIDTH           = 8,
    parameter int EDGE_TYPE       = 0,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

`ifdef PIO_IN_DEBOUNCE_EN
    localparam int WARM_CYCLES = SYNC_STAGES + 1 + DEBOUNCE_CYCLES;
`else
    localparam int WARM_CYCLES = SYNC_STAGES + 1;
`endif
    localparam int WARM_W = $clog2(WARM_CYCLES + 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  sync;
    logic [WIDTH-1:0]                  filt;
    logic [WIDTH-1:0]                  prev;
    logic [WIDTH-1:0]                  edge_raw;
    logic [WIDTH-1:0]                  edge_det;
    logic [WIDTH-1:0]                  clr;
    logic [WIDTH-1:0]                  irqmask;
    logic [WIDTH-1:0]                  edgecap;
    logic [WARM_W-1:0]                 warm_cnt;
    logic                              warm_done;
    logic                              wr_en;
    logic [31:0]                       rd_mux;
    logic                              unused_wdata;

    // Synchroniser stage boundary
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

`ifdef PIO_IN_DEBOUNCE_EN
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);

    logic [WIDTH-1:0][DB_W-1:0] db_cnt;

    // A bit is accepted only after it differs from filt for DEBOUNCE_CYCLES edges in a row
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            db_cnt <= '0;
            filt   <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync[i] == filt[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    filt[i]   <= sync[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end
`else
    assign filt = sync;
`endif

    assign warm_done = (warm_cnt == WARM_W'(WARM_CYCLES));

    // Levels present at reset release must not look like edges
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            warm_cnt <= '0;
        end else if (!warm_done) begin
            warm_cnt <= warm_cnt + 1'b1;
        end
    end

    always_comb begin
        if (EDGE_TYPE == 0) begin
            edge_raw = filt & ~prev;
        end else if (EDGE_TYPE == 1) begin
            edge_raw = ~filt & prev;
        end else begin
            edge_raw = filt ^ prev;
        end
        edge_det = warm_done ? edge_raw : '0;
    end

    assign wr_en        = chipselect & ~write_n;
    assign clr          = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
    assign unused_wdata = ^writedata;

    always_comb begin
        rd_mux = '0;
        case (address)
            2'd0:    rd_mux[WIDTH-1:0] = filt;
            2'd2:    rd_mux[WIDTH-1:0] = irqmask;
            2'd3:    rd_mux[WIDTH-1:0] = edgecap;
            default: rd_mux = '0;
        endcase
    end

    // Edge/register stage boundary; set beats clear on the same bit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev     <= '0;
            edgecap  <= '0;
            irqmask  <= '0;
            readdata <= '0;
        end else begin
            prev     <= filt;
            edgecap  <= (edgecap & ~clr) | edge_det;
            readdata <= rd_mux;
            if (wr_en && address == 2'd2) begin
                irqmask <= writedata[WIDTH-1:0];
            end
        end
    end

    assign irq = |(edgecap & irqmask);

endmodule

// File: doc/pio_in_edge_irq.md
# pio_in_edge_irq

Parametrised Avalon-MM input PIO with a synchroniser, an edge-capture register, a per-bit interrupt mask and an interrupt line. It generalises the fixed 8-bit read-only switch port to 1..32 bits and adds edge detection and IRQ generation. It sits between board-level inputs (switches, keys) and the Qsys interconnect as an `s1` slave with an `irq` sender. An optional debounce filter is selected at compile time.

## Interface

Parameters:
- `WIDTH`, default 8, input width in bits; legal range 1..32.
- `EDGE_TYPE`, default 0, edge that is captured: 0 = rising, 1 = falling, 2 = any.
- `SYNC_STAGES`, default 2, synchroniser flop depth; legal range 2..4.
- `DEBOUNCE_CYCLES`, default 16, required stable cycles; used only when debounce is compiled in; legal range 2..65535.

Ports:
- `clk` in 1: clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `address` in 2: word address.
- `chipselect` in 1: write qualifier.
- `write_n` in 1: active-low write strobe.
- `writedata` in 32: write data.
- `in_port` in WIDTH: asynchronous external inputs.
- `readdata` out 32: registered read data.
- `irq` out 1: level interrupt, active-high.

## Operation

- **Register map:**
  - 0: DATA, read-only, filtered input.
  - 1: reserved, reads 0.
  - 2: IRQMASK, read/write, WIDTH bits.
  - 3: EDGECAP, read / write-1-to-clear.
  - Bits above WIDTH read 0. Writes to addresses 0 and 1 are ignored.
- **Write:** a write occurs when `chipselect=1` and `write_n=0`.
- **Synchroniser:** each bit of `in_port` passes through SYNC_STAGES flops. All flops reset to 0.
- **Filtered value `filt`:**
  - Without debounce, `filt` equals the synchroniser output.
  - With debounce, see Configuration.
- **Edge detect:**
  - Register `prev <= filt` every cycle; `prev` resets to 0.
  - Rising edge: `filt & ~prev`. Falling edge: `~filt & prev`. Any edge: `filt ^ prev`.
- **Warm-up:** a counter runs for SYNC_STAGES+1 cycles after reset deassertion (plus DEBOUNCE_CYCLES when debounce is compiled in). Edge detection is gated off until the counter completes, so input levels present at reset release are never captured as edges.
- **EDGECAP update:** `edgecap <= (edgecap & ~clr) | edge`.
  - `clr` is `writedata[WIDTH-1:0]` on a write to address 3, and 0 otherwise.
  - If an edge and a clear hit the same bit in the same cycle, set wins.
- **IRQ:** `irq = |(edgecap & irqmask)`, driven combinationally from registers only, with no path from `in_port` or the bus. Writing IRQMASK never alters EDGECAP.
- **Read:** `readdata <=` the mux of `address`, updated every cycle (unqualified, as for the existing PIO), zero-extended to 32 bits.
- **Reset values:** `readdata`, `irq`, `irqmask`, `edgecap`, `prev`, synchroniser flops, debounce state and warm-up counter are all 0.
- **Reset asserted mid-operation:** all state clears asynchronously and the warm-up restarts.

## Timing

- **Read latency:** 1 clock. `readdata` reflects the `address` value sampled at the preceding rising edge.
- **`in_port` to DATA:** a change stable before edge N appears in `filt` after edge N+SYNC_STAGES-1. It is visible on `readdata` one edge later.
- **`filt` change to EDGECAP/`irq`:** EDGECAP bit set and `irq` high after the next edge (1 cycle).
- **Clear:** a write-1-to-clear at edge N drops the EDGECAP bit after edge N; `irq` falls in the same cycle unless another enabled bit is set.
- **IRQMASK:** a write at edge N affects `irq` immediately after edge N.
- **Debounce:** adds DEBOUNCE_CYCLES cycles to the `in_port`-to-`filt` latency.

## Configuration

- Macro: `PIO_IN_DEBOUNCE_EN`.
- **Defined:**
  - Each bit has a counter of width clog2(DEBOUNCE_CYCLES).
  - The counter resets to 0 whenever `sync == filt`, and otherwise increments.
  - When the count reaches DEBOUNCE_CYCLES-1 while `sync != filt`, then `filt <= sync` and the count returns to 0.
  - An input change must therefore persist for DEBOUNCE_CYCLES consecutive cycles to be accepted. Shorter glitches never reach DATA or EDGECAP.
- **Undefined:** no counters, `filt` = synchroniser output, and the DEBOUNCE_CYCLES parameter is ignored.

## Test plan

Defaults for all scenarios unless stated: WIDTH=8, EDGE_TYPE=0, SYNC_STAGES=2.

1. **Reset and warm-up:** hold `in_port=8'hFF` through reset release, idle 10 cycles → `readdata` reads EDGECAP 0x00000000, `irq=0`, DATA 0x000000FF.
2. **DATA latency:** `in_port` 0x00→0xA5 at edge N, `address=0` → `readdata=0x000000A5` after edge N+2, not before.
3. **Edge capture, IRQ and clear:**
   - Write IRQMASK=0x01, then raise bit 0 → EDGECAP=0x01 and `irq=1` one cycle after `filt` rises.
   - Write 0x01 to address 3 → EDGECAP=0x00 and `irq=0` after the write edge.
4. **Simultaneous clear and edge:** a write-1-to-clear of bit 0 in the same cycle as a new bit-0 rising edge → EDGECAP stays 0x01 and `irq` stays 1.
5. **Any-edge, masked:** EDGE_TYPE=2, IRQMASK=0, bit 7 falls 1→0 → EDGECAP=0x80 and `irq` stays 0. Then write IRQMASK=0x80 → `irq=1` next cycle.
6. **Debounce:** DEBOUNCE_CYCLES=4.
   - With `PIO_IN_DEBOUNCE_EN` defined: a 3-cycle pulse on bit 2 leaves DATA=0x00 and EDGECAP=0x00; a 4-cycle hold gives DATA=0x04.
   - With the macro undefined: the same 3-cycle pulse sets EDGECAP=0x04.
